// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and instruction memory (slave).
// Handshake: the master raises imem_req with imem_addr and holds both stable until a cycle in
// which imem_ack is sampled high; that cycle carries imem_rdata and completes the request.
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// IF stage of the multicycle Lua core: one instruction-memory read per clk_if strobe,
// latches the instruction into ir, advances the PC and applies EX branch redirects.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               clk_if,
  input  logic               halt,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  instr_fetch_if.master      imem,
  output logic [DATA_W-1:0]  ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic               busy,
  output logic [7:0]         overrun_cnt,
  output logic               dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic issue;
  assign issue = (state_q == S_IDLE) && clk_if && !halt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_WAIT;
      S_WAIT: if (imem.imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == S_WAIT);
    dbg_state     = (state_q == S_WAIT);
    imem.imem_req = (state_q == S_WAIT);
  end

  // Datapath: a redirect seen in WAIT without ack is parked in tgt_q and the
  // in-flight data is squashed; a redirect coinciding with ack applies directly.
  always_comb begin
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    overrun_d  = overrun_q;
    squash_d   = squash_q;
    tgt_d      = tgt_q;
    if (state_q == S_IDLE) begin
      if (br_valid) pc_d = br_target;
      if (issue) begin
        addr_d     = br_valid ? br_target : pc_q;
        ir_valid_d = 1'b0;
        squash_d   = 1'b0;
      end
    end else begin
      if (clk_if && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
      if (imem.imem_ack) begin
        squash_d = 1'b0;
        if (br_valid) begin
          pc_d = br_target;
        end else if (squash_q) begin
          pc_d = tgt_q;
        end else begin
          ir_d       = imem.imem_rdata;
          ir_pc_d    = addr_q;
          ir_valid_d = 1'b1;
          pc_d       = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end else if (br_valid) begin
        squash_d = 1'b1;
        tgt_d    = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      overrun_q  <= 8'd0;
      squash_q   <= 1'b0;
      tgt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      overrun_q  <= overrun_d;
      squash_q   <= squash_d;
      tgt_q      <= tgt_d;
    end
  end

  assign imem.imem_addr = addr_q;
  assign ir             = ir_q;
  assign ir_pc          = ir_pc_q;
  assign ir_valid       = ir_valid_q;
  assign overrun_cnt    = overrun_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (RESET_PC 0 and 0xFFFF) driven in lockstep, a
// per-instance expected queue of {ir_pc, ir} popped whenever ir_valid rises.
module tb_instr_fetch;
  localparam int AW = 16;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic          clk_if = 1'b0, halt = 1'b0, br_valid = 1'b0, ack = 1'b0;
  logic [AW-1:0] br_target = '0;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  logic [DW-1:0] ir0, ir1;
  logic [AW-1:0] ir_pc0, ir_pc1;
  logic          ir_valid0, ir_valid1, busy0, busy1, dbg0, dbg1;
  logic [7:0]    ovr0, ovr1;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .n_reset(n_reset), .clk_if(clk_if), .halt(halt),
    .br_valid(br_valid), .br_target(br_target), .imem(bus0.master),
    .ir(ir0), .ir_pc(ir_pc0), .ir_valid(ir_valid0), .busy(busy0),
    .overrun_cnt(ovr0), .dbg_state(dbg0));

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .n_reset(n_reset), .clk_if(clk_if), .halt(halt),
    .br_valid(br_valid), .br_target(br_target), .imem(bus1.master),
    .ir(ir1), .ir_pc(ir_pc1), .ir_valid(ir_valid1), .busy(busy1),
    .overrun_cnt(ovr1), .dbg_state(dbg1));

  // Instruction memory contents: word 0 holds 0x00004001, every other word is {C0DE, addr}.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == '0) ? 32'h0000_4001 : {16'hC0DE, a};
  endfunction

  assign bus0.imem_ack   = ack;
  assign bus1.imem_ack   = ack;
  assign bus0.imem_rdata = mem_word(bus0.imem_addr);
  assign bus1.imem_rdata = mem_word(bus1.imem_addr);

  // scoreboard
  int n_chk = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] exp0_q[$];
  logic [AW+DW-1:0] exp1_q[$];
  logic pv0 = 1'b0, pv1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ir_valid0 && !pv0) begin
      if (exp0_q.size() == 0) chk("ir0_unexpected", {ir_pc0, ir0}, 64'hDEAD_DEAD_DEAD_DEAD);
      else chk("ir0_latch", {ir_pc0, ir0}, exp0_q.pop_front());
    end
    pv0 <= ir_valid0;
  end

  always @(negedge clk) begin
    if (ir_valid1 && !pv1) begin
      if (exp1_q.size() == 0) chk("ir1_unexpected", {ir_pc1, ir1}, 64'hDEAD_DEAD_DEAD_DEAD);
      else chk("ir1_latch", {ir_pc1, ir1}, exp1_q.pop_front());
    end
    pv1 <= ir_valid1;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobe(input logic br, input logic [AW-1:0] tgt);
    clk_if = 1'b1; br_valid = br; br_target = tgt;
    tick();
    clk_if = 1'b0; br_valid = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_req",      bus0.imem_req,  0);
    chk("rst_addr",     bus0.imem_addr, 0);
    chk("rst_ir",       ir0,            0);
    chk("rst_ir_pc",    ir_pc0,         0);
    chk("rst_ir_valid", ir_valid0,      0);
    chk("rst_busy",     busy0,          0);
    chk("rst_ovr",      ovr0,           0);
    chk("rst_state",    dbg0,           0);
    chk("rst_req1",     bus1.imem_req,  0);
    n_reset = 1'b1;
    tick();

    // T1: zero-wait fetch from reset PC
    strobe(1'b0, '0);
    chk("t1_req",   bus0.imem_req,  1);
    chk("t1_addr0", bus0.imem_addr, 16'h0000);
    chk("t1_addr1", bus1.imem_addr, 16'hFFFF);
    exp0_q.push_back({16'h0000, 32'h0000_4001});
    exp1_q.push_back({16'hFFFF, 32'hC0DE_FFFF});
    do_ack();
    chk("t1_req_one_cycle", bus0.imem_req, 0);
    chk("t1_ir_valid",      ir_valid0,     1);

    // T2: three wait cycles with a lost strobe in the middle
    strobe(1'b0, '0);
    exp0_q.push_back({16'h0001, 32'hC0DE_0001});
    exp1_q.push_back({16'h0000, 32'h0000_4001});
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr_stable", bus0.imem_addr, 16'h0001);
      chk("t2_req_held",    bus0.imem_req,  1);
      clk_if = (i == 1);
      tick();
    end
    clk_if = 1'b0;
    chk("t2_addr_stable", bus0.imem_addr, 16'h0001);
    do_ack();
    chk("t2_ovr0", ovr0,  1);
    chk("t2_ovr1", ovr1,  1);
    chk("t2_busy", busy0, 0);

    // T4: redirect in the same cycle as the strobe
    strobe(1'b1, 16'h0020);
    chk("t4_addr0", bus0.imem_addr, 16'h0020);
    chk("t4_addr1", bus1.imem_addr, 16'h0020);
    exp0_q.push_back({16'h0020, 32'hC0DE_0020});
    exp1_q.push_back({16'h0020, 32'hC0DE_0020});
    do_ack();
    strobe(1'b0, '0);
    chk("t4_pc_next", bus0.imem_addr, 16'h0021);
    exp0_q.push_back({16'h0021, 32'hC0DE_0021});
    exp1_q.push_back({16'h0021, 32'hC0DE_0021});
    do_ack();

    // T3: redirects during WAIT squash the fetch at 5; the later target wins
    strobe(1'b1, 16'h0005);
    chk("t3_addr", bus0.imem_addr, 16'h0005);
    chk("t3_busy", busy0, 1);
    tick();
    br_valid = 1'b1; br_target = 16'h0080;
    tick();
    br_target = 16'h0100;
    tick();
    br_valid = 1'b0;
    tick();
    do_ack();
    chk("t3_squash0", ir_valid0, 0);
    chk("t3_squash1", ir_valid1, 0);
    chk("t3_idle",    busy0,     0);
    strobe(1'b0, '0);
    chk("t3_next_addr", bus0.imem_addr, 16'h0100);
    exp0_q.push_back({16'h0100, 32'hC0DE_0100});
    exp1_q.push_back({16'h0100, 32'hC0DE_0100});
    do_ack();

    // redirect coinciding with ack discards the data and redirects directly
    strobe(1'b0, '0);
    chk("brack_addr", bus0.imem_addr, 16'h0101);
    tick();
    ack = 1'b1; br_valid = 1'b1; br_target = 16'h0040;
    tick();
    ack = 1'b0; br_valid = 1'b0;
    chk("brack_squash", ir_valid0, 0);

    // T5: halt raised mid-fetch lets it complete, then blocks new issues
    strobe(1'b0, '0);
    chk("t5_addr", bus0.imem_addr, 16'h0040);
    exp0_q.push_back({16'h0040, 32'hC0DE_0040});
    exp1_q.push_back({16'h0040, 32'hC0DE_0040});
    halt = 1'b1;
    tick();
    do_ack();
    chk("t5_halt_completes", ir_valid0, 1);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, '0);
      chk("t5_halt_no_req0", bus0.imem_req, 0);
      chk("t5_halt_no_req1", bus1.imem_req, 0);
      tick();
    end
    do_ack();
    chk("idle_ack_ir",       ir0,       32'hC0DE_0040);
    chk("idle_ack_ir_valid", ir_valid0, 1);

    // T6: asynchronous reset in the middle of WAIT
    halt = 1'b0;
    strobe(1'b0, '0);
    chk("t6_busy", busy0, 1);
    #2 n_reset = 1'b0;
    #1;
    chk("t6_req0",      bus0.imem_req, 0);
    chk("t6_busy0",     busy0,         0);
    chk("t6_ir_valid0", ir_valid0,     0);
    chk("t6_req1",      bus1.imem_req, 0);
    tick();
    n_reset = 1'b1;
    tick();
    chk("t6_ovr_cleared", ovr0, 0);
    strobe(1'b0, '0);
    chk("t6_addr0", bus0.imem_addr, 16'h0000);
    chk("t6_addr1", bus1.imem_addr, 16'hFFFF);
    exp0_q.push_back({16'h0000, 32'h0000_4001});
    exp1_q.push_back({16'hFFFF, 32'hC0DE_FFFF});

    // overrun counter saturates at 255 under a long stall
    clk_if = 1'b1;
    repeat (260) tick();
    clk_if = 1'b0;
    chk("sat_ovr0", ovr0, 8'hFF);
    chk("sat_ovr1", ovr1, 8'hFF);
    do_ack();
    chk("sat_done", busy0, 0);

    repeat (2) tick();
    chk("sb0_drained", exp0_q.size(), 0);
    chk("sb1_drained", exp1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
